// File: rtl/warp_pkg.sv
// Shared types and constants for the warp dispatcher: FSM states and the
// queued instruction entry.
package warp_pkg;

  localparam int INST_W        = 32;
  localparam int NUM_LANES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT
  } dispatch_state_e;

  typedef struct packed {
    logic [INST_W-1:0]        inst;
    logic [NUM_LANES_DEF-1:0] mask;
  } dispatch_entry_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Small synchronous FIFO of dispatch entries; pointers carry an extra wrap
// bit so full and empty can be told apart.
module dispatch_fifo #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              clear,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wrPtr_q;
  logic [AW:0]       rdPtr_q;

  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign head  = mem_q[rdPtr_q[AW-1:0]];

  // clear wins over push and pop so a flushed cycle leaves the FIFO empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else if (clear) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push && !full) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop && !empty) rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem_q[wrPtr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/warp_dispatcher.sv
// Buffers masked instructions and issues them one at a time to all lanes,
// waiting for every enabled lane to come back ready (or timing out).
module warp_dispatcher
  import warp_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [INST_W-1:0]    in_inst,
  input  logic [NUM_LANES-1:0] in_mask,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [INST_W-1:0]    instruction,
  output logic [NUM_LANES-1:0] lane_enable,
  output logic                 execute,
  input  logic [NUM_LANES-1:0] lane_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     retired_count
);

  localparam int ENTRY_W = INST_W + NUM_LANES;
  localparam int WCNT_W  = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [INST_W-1:0]    inst;
    logic [NUM_LANES-1:0] mask;
  } entry_t;

  entry_t          pushEntry;
  entry_t          headEntry;
  logic [ENTRY_W-1:0] headVec;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            fifoPush;
  logic            fifoPop;

  dispatch_state_e      state_q, state_d;
  logic [WCNT_W-1:0]    waitCnt_q, waitCnt_d;
  logic [INST_W-1:0]    inst_q, inst_d;
  logic [NUM_LANES-1:0] enable_q, enable_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_W-1:0]     retired_q, retired_d;

  assign pushEntry = '{inst: in_inst, mask: in_mask};
  assign headEntry = entry_t'(headVec);
  // a push that lands on a flush cycle is dropped along with the queue
  assign fifoPush  = in_valid && !fifoFull && !flush;

  dispatch_fifo #(
    .DATA_W(ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifoPush),
    .din  (pushEntry),
    .pop  (fifoPop),
    .clear(flush),
    .full (fifoFull),
    .empty(fifoEmpty),
    .head (headVec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      inst_q    <= '0;
      enable_q  <= '0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      inst_q    <= inst_d;
      enable_q  <= enable_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    inst_d    = inst_q;
    enable_d  = enable_q;
    timeout_d = timeout_q;
    retired_d = retired_q;
    fifoPop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty && !flush) begin
          // empty-mask entries retire without ever reaching the lanes
          if (headEntry.mask == '0) begin
            fifoPop   = 1'b1;
            retired_d = retired_q + CNT_W'(1);
          end else if (&(lane_ready | ~headEntry.mask)) begin
            fifoPop  = 1'b1;
            inst_d   = headEntry.inst;
            enable_d = headEntry.mask;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: state_d = GUARD;
      GUARD: begin
        waitCnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (&(lane_ready | ~enable_q)) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = IDLE;
        end else if (waitCnt_q == WCNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          retired_d = retired_q + CNT_W'(1);
          state_d   = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + WCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready      = !fifoFull;
  assign instruction   = inst_q;
  assign lane_enable   = enable_q;
  assign execute       = (state_q == ISSUE);
  assign busy          = (state_q != IDLE) || !fifoEmpty;
  assign timeout_err   = timeout_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_warp_dispatcher.sv
// Self-checking bench for warp_dispatcher: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_warp_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [7:0]  in_mask;
  logic        in_ready;
  logic        flush;
  logic [31:0] instruction;
  logic [7:0]  lane_enable;
  logic        execute;
  logic [7:0]  lane_ready;
  logic        busy;
  logic        timeout_err;
  logic [15:0] retired_count;

  int vectors;
  int miscompares;

  warp_dispatcher dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_inst      (in_inst),
    .in_mask      (in_mask),
    .in_ready     (in_ready),
    .flush        (flush),
    .instruction  (instruction),
    .lane_enable  (lane_enable),
    .execute      (execute),
    .lane_ready   (lane_ready),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of pending work plus the age (cycles since
  // the pop) of the instruction currently out at the lanes, -1 if none.
  typedef struct {
    logic [31:0] inst;
    logic [7:0]  mask;
  } mentry_t;

  mentry_t     mq[$];
  int          mAge;
  logic [31:0] mInst;
  logic [7:0]  mEn;
  logic        mTo;
  logic [15:0] mRet;

  logic [59:0] obs;
  assign obs = {in_ready, busy, execute, timeout_err, retired_count, lane_enable, instruction};

  function automatic logic [59:0] expVec();
    logic rdy, bsy, ex;
    rdy = (mq.size() < DEPTH);
    bsy = (mAge >= 0) || (mq.size() != 0);
    ex  = (mAge == 0);
    return {rdy, bsy, ex, mTo, mRet, mEn, mInst};
  endfunction

  task automatic modelReset();
    mq.delete();
    mAge  = -1;
    mInst = '0;
    mEn   = '0;
    mTo   = 1'b0;
    mRet  = '0;
  endtask

  task automatic modelStep();
    bit doPush;
    doPush = in_valid && (mq.size() < DEPTH) && !flush;
    if (mAge < 0) begin
      if (mq.size() != 0 && !flush) begin
        if (mq[0].mask == 8'h00) begin
          void'(mq.pop_front());
          mRet = mRet + 16'd1;
        end else if ((lane_ready | ~mq[0].mask) == 8'hFF) begin
          mInst = mq[0].inst;
          mEn   = mq[0].mask;
          void'(mq.pop_front());
          mAge  = 0;
        end
      end
    end else if (mAge < 2) begin
      mAge++;
    end else if ((lane_ready | ~mEn) == 8'hFF) begin
      mRet = mRet + 16'd1;
      mAge = -1;
    end else if (mAge - 2 == TIMEOUT - 1) begin
      mTo  = 1'b1;
      mRet = mRet + 16'd1;
      mAge = -1;
    end else begin
      mAge++;
    end
    if (flush) mq.delete();
    if (doPush) mq.push_back('{inst: in_inst, mask: in_mask});
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_inst = '0; in_mask = '0; flush = 1'b0; lane_ready = 8'hFF;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL reset_state got=%h want=%h", obs, expVec());
    end
    rst = 1'b0;
    repeat (2) begin
      tick();
      vectors++;
      if (obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL reset_idle got=%h want=%h", obs, expVec());
      end
    end
  endtask

  task automatic test_single_issue();
    in_valid = 1'b1; in_inst = 32'h1234_5678; in_mask = 8'hFF; lane_ready = 8'hFF;
    for (int t = 0; t < 12; t++) begin
      if (t == 1) in_valid = 1'b0;
      lane_ready = (t >= 2 && t <= 4) ? 8'h00 : 8'hFF;
      tick();
      vectors++;
      if (obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL single_issue t=%0d got=%h want=%h", t, obs, expVec());
      end
      vectors++;
      if (execute !== (t == 1)) begin
        miscompares++;
        $display("[TB] FAIL single_exec_timing t=%0d got=%b want=%b", t, execute, (t == 1));
      end
      if (t == 1) begin
        vectors++;
        if ({instruction, lane_enable} !== {32'h1234_5678, 8'hFF}) begin
          miscompares++;
          $display("[TB] FAIL single_broadcast got=%h/%h want=12345678/ff", instruction, lane_enable);
        end
      end
    end
    vectors++;
    if (retired_count !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL single_retired got=%0d want=1", retired_count);
    end
  endtask

  task automatic test_masked_ready();
    logic [15:0] startRet;
    startRet = mRet;
    in_valid = 1'b1; in_inst = $urandom; in_mask = 8'h0F; lane_ready = 8'h0F;
    for (int t = 0; t < 8; t++) begin
      tick();
      in_valid = 1'b0;
      vectors++;
      if (obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL masked t=%0d got=%h want=%h", t, obs, expVec());
      end
    end
    vectors++;
    if ({timeout_err, retired_count} !== {1'b0, startRet + 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL masked_retire got=%b/%0d want=0/%0d", timeout_err, retired_count, startRet + 16'd1);
    end
  endtask

  task automatic test_zero_mask();
    logic [15:0] startRet;
    int pulses;
    startRet = mRet;
    pulses = 0;
    lane_ready = 8'hFF;
    for (int t = 0; t < 10; t++) begin
      in_valid = (t < 2);
      in_inst  = $urandom;
      in_mask  = (t == 0) ? 8'h00 : 8'h33;
      tick();
      if (execute === 1'b1) pulses++;
      vectors++;
      if (obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL zero_mask t=%0d got=%h want=%h", t, obs, expVec());
      end
    end
    vectors++;
    if (pulses != 1 || retired_count !== startRet + 16'd2) begin
      miscompares++;
      $display("[TB] FAIL zero_mask_count got=%0d pulses/%0d retired want=1/%0d", pulses, retired_count, startRet + 16'd2);
    end
  endtask

  task automatic test_full_timeout();
    bit sawFull, sawExec;
    sawFull = 0;
    lane_ready = 8'hFF;
    for (int t = 0; t < 5; t++) begin
      in_valid = 1'b1; in_inst = $urandom; in_mask = 8'hFF;
      tick();
      if (execute === 1'b1) lane_ready = 8'hFE;
      if (in_ready === 1'b0) sawFull = 1;
      vectors++;
      if (obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL full t=%0d got=%h want=%h", t, obs, expVec());
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (!sawFull) begin
      miscompares++;
      $display("[TB] FAIL full_in_ready got=never-low want=low");
    end
    for (int t = 0; t < 45 && timeout_err !== 1'b1; t++) begin
      tick();
      vectors++;
      if (obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL timeout_wait t=%0d got=%h want=%h", t, obs, expVec());
      end
    end
    vectors++;
    if (timeout_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_flag got=%b want=1", timeout_err);
    end
    lane_ready = 8'hFF;
    sawExec = 0;
    for (int t = 0; t < 40 && busy !== 1'b0; t++) begin
      tick();
      if (execute === 1'b1) sawExec = 1;
      vectors++;
      if (obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL drain t=%0d got=%h want=%h", t, obs, expVec());
      end
    end
    vectors++;
    if (!sawExec || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL next_issue got=exec%0b/busy%b want=exec1/busy0", sawExec, busy);
    end
  endtask

  task automatic test_flush();
    logic [15:0] startRet;
    startRet = mRet;
    lane_ready = 8'hFF;
    for (int t = 0; t < 16; t++) begin
      in_valid   = (t < 3);
      in_inst    = $urandom;
      in_mask    = 8'hFF;
      flush      = (t == 5);
      lane_ready = (t >= 2 && t <= 5) ? 8'h00 : 8'hFF;
      tick();
      vectors++;
      if (obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL flush t=%0d got=%h want=%h", t, obs, expVec());
      end
    end
    flush = 1'b0;
    vectors++;
    if ({busy, retired_count} !== {1'b0, startRet + 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL flush_result got=%b/%0d want=0/%0d", busy, retired_count, startRet + 16'd1);
    end
  endtask

  task automatic test_reset_mid();
    lane_ready = 8'hFF;
    in_valid = 1'b1; in_inst = 32'hCAFE_F00D; in_mask = 8'hA5;
    for (int t = 0; t < 4 && execute !== 1'b1; t++) begin
      tick();
      in_valid = 1'b0;
    end
    vectors++;
    if (execute !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_issue got=%b want=1", execute);
    end
    rst = 1'b1;
    modelReset();
    #1;
    vectors++;
    if (obs !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL reset_mid got=%h want=%h", obs, expVec());
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick();
    vectors++;
    if (obs !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL reset_release got=%h want=%h", obs, expVec());
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      in_valid   = $urandom_range(0, 1);
      in_inst    = $urandom;
      in_mask    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      flush      = ($urandom_range(0, 31) == 0);
      lane_ready = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      if ($urandom_range(0, 99) < 3) lane_ready = 8'h00;
      tick();
      vectors++;
      if (obs !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL random t=%0d got=%h want=%h", t, obs, expVec());
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_issue();
    test_masked_ready();
    test_zero_mask();
    test_full_timeout();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/warp_dispatcher.md
Name: warp_dispatcher

Overview:
- Upstream stage of the processing lanes. Buffers instructions from the front end in a small FIFO, each tagged with a lane mask.
- Issues one instruction at a time to all lanes: broadcast instruction word, per-lane lane_enable, single-cycle execute pulse.
- Waits until every enabled lane reports ready before issuing the next instruction.
- Flags lanes that never return ready via a sticky timeout error.

Parameters:
- NUM_LANES, 8, number of processing lanes driven.
- DEPTH, 4, instruction FIFO entries (power of two, >=2).
- TIMEOUT, 32, max cycles in WAIT before forced retire.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, front end presents an instruction.
- in_inst, in, 32, instruction word (not decoded here).
- in_mask, in, NUM_LANES, lanes that must execute in_inst.
- in_ready, out, 1, FIFO can accept (= !full).
- flush, in, 1, synchronous clear of queued, unissued entries.
- instruction, out, 32, broadcast instruction to lanes.
- lane_enable, out, NUM_LANES, per-lane enable.
- execute, out, 1, one-cycle issue strobe.
- lane_ready, in, NUM_LANES, per-lane ready.
- busy, out, 1, FSM not in IDLE or FIFO non-empty.
- timeout_err, out, 1, sticky: a WAIT timed out.
- retired_count, out, CNT_W, instructions retired, including dropped and timed-out ones.

Behaviour:
- Reset (async, rst=1): FIFO empty; state IDLE; execute=0; instruction=0; lane_enable=0; timeout_err=0; retired_count=0; in_ready=1.
- Push: occurs when in_valid && in_ready; {in_inst, in_mask} are written at the posedge.
- No same-cycle bypass. in_ready depends on full only, so a full FIFO refuses a push even when a pop occurs in the same cycle.
- FSM states: IDLE, ISSUE, GUARD, WAIT.
- IDLE, FIFO non-empty, head mask == 0:
  - pop the entry; increment retired_count; no execute pulse; stay IDLE.
- IDLE, FIFO non-empty, mask != 0, and (lane_ready | ~mask) all ones:
  - pop the entry; register instruction <= head inst and lane_enable <= head mask; go to ISSUE.
- ISSUE: execute=1 for exactly this cycle; next state GUARD.
- GUARD: one cycle; lane_ready is ignored so lanes have time to drop ready; next state WAIT; wait counter cleared.
- WAIT:
  - if (lane_ready | ~lane_enable) is all ones: retire (retired_count+1, wraps at 2^CNT_W) and go to IDLE.
  - else if wait counter == TIMEOUT-1: set timeout_err, retire, go to IDLE.
  - else increment the wait counter.
- Minimum issue-to-issue spacing: 4 cycles (IDLE, ISSUE, GUARD, WAIT). Push-to-execute latency into an idle, empty dispatcher: 2 cycles.
- instruction and lane_enable hold their value until the next pop into ISSUE; they are not cleared in IDLE.
- execute is 0 in every state except ISSUE.
- flush: empties the FIFO next cycle. An in-flight instruction (ISSUE/GUARD/WAIT) completes normally. A push coinciding with flush is discarded. flush has priority over pop in IDLE.
- timeout_err clears only on rst.
- rst mid-operation: immediate return to the reset values above; a pending execute pulse is cut off.

Decomposition:
- warp_pkg additions:
  - dispatch_state_e (IDLE, ISSUE, GUARD, WAIT);
  - INST_W = 32;
  - default NUM_LANES constant;
  - dispatch entry struct {inst, mask}.
- Sub-module dispatch_fifo: synchronous FIFO of entries, parameter DEPTH. Ports: push, pop, clear, full, empty, head. Pointers wrap with an extra MSB for the full/empty test.

Test Plan:
- Reset then idle: after rst deasserts, in_ready=1, busy=0, execute=0, lane_enable=0, retired_count=0.
- Single issue: push inst 0x1234_5678 with mask 0xFF while all lanes are ready.
  - execute high exactly 1 cycle, 2 cycles after the push; instruction=0x1234_5678; lane_enable=0xFF.
  - Lanes drop ready for 3 cycles; retired_count=1 after they recover.
- Masked readiness: mask 0x0F, lanes 4-7 held not ready, lanes 0-3 return ready -> retire, with no timeout_err.
- Zero mask: push mask 0x00 -> no execute pulse; retired_count increments; next entry issues normally.
- Full FIFO: push 5 entries back-to-back with lane 0 never ready.
  - in_ready=0 once 4 entries are queued.
  - After 32 WAIT cycles, timeout_err=1 and the next entry issues.
- Flush and reset mid-flight:
  - flush during WAIT -> current instruction retires, queued entries are dropped, busy=0.
  - rst asserted during ISSUE -> execute=0 immediately and all outputs return to their reset values.
